// File: rtl/canon_huff_pkg.sv
// Shared types and table-access helpers for the canonical Huffman decoder.
package canon_huff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int unsigned VEC_W = 1024;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [31:0] field_at(
        input logic [VEC_W-1:0] v,
        input int unsigned      idx,
        input int unsigned      w
    );
        logic [VEC_W-1:0] s;
        s = v >> (idx * w);
        return s[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

    // len is 1-based: length 1 lives in slice 0
    function automatic logic [31:0] len_at(
        input logic [VEC_W-1:0] lc,
        input int unsigned      len,
        input int unsigned      w
    );
        return field_at(lc, len - 1, w);
    endfunction

    function automatic logic [31:0] sym_at(
        input logic [VEC_W-1:0] st,
        input int unsigned      idx,
        input int unsigned      w
    );
        return field_at(st, idx, w);
    endfunction

endpackage

// File: rtl/canon_huff_step.sv
// One canonical-code length step: match test and next first/index.
module canon_huff_step #(
    parameter int unsigned MAX_LEN = 4,
    parameter int unsigned NUM_SYM = 16,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned CW      = MAX_LEN + 1,
    parameter int unsigned IW      = $clog2(NUM_SYM) + 1
) (
    input  logic [CW-1:0]    code_i,
    input  logic [CW-1:0]    first_i,
    input  logic [IW-1:0]    index_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             bit_i,
    output logic             match_o,
    output logic [IW-1:0]    offset_o,
    output logic [CW-1:0]    next_code_o,
    output logic [CW-1:0]    next_first_o,
    output logic [IW-1:0]    next_index_o,
    output logic             overflow_o
);

    logic [31:0] c;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] off;

    // 32-bit arithmetic so nothing wraps inside the step
    assign c   = 32'({code_i, bit_i});
    assign lo  = 32'(first_i);
    assign hi  = lo + 32'(count_i);
    assign off = 32'(index_i) + c - lo;

    assign match_o      = (c >= lo) && (c < hi);
    assign overflow_o   = match_o && (off >= NUM_SYM);
    assign offset_o     = IW'(off);
    assign next_code_o  = CW'(c);
    assign next_first_o = CW'(hi << 1);
    assign next_index_o = IW'(32'(index_i) + 32'(count_i));

endmodule

// File: rtl/canon_huff_dec.sv
// Bit-serial canonical Huffman decoder feeding a write FIFO.
module canon_huff_dec
    import canon_huff_pkg::*;
#(
    parameter int unsigned SYM_W   = 4,
    parameter int unsigned NUM_SYM = 16,
    parameter int unsigned MAX_LEN = 4,
    parameter int unsigned TOT_W   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [TOT_W-1:0]                 sym_total,
    input  logic [MAX_LEN*cnt_w(NUM_SYM)-1:0] len_count,
    input  logic [NUM_SYM*SYM_W-1:0]         sym_table,
    input  logic                             bit_in,
    input  logic                             bit_vld,
    output logic                             bit_req,
    output logic [SYM_W-1:0]                 wdata,
    output logic                             winc,
    input  logic                             wfull,
    output logic                             busy,
    output logic                             fin,
    output logic                             err
);

    localparam int unsigned CNT_W = cnt_w(NUM_SYM);
    localparam int unsigned CW    = MAX_LEN + 1;
    localparam int unsigned IW    = $clog2(NUM_SYM) + 1;
    localparam int unsigned LW    = $clog2(MAX_LEN + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CW-1:0]    first_q, first_d;
    logic [IW-1:0]    index_q, index_d;
    logic [LW-1:0]    len_q, len_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic [TOT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] wdata_q, wdata_d;

    logic [CNT_W-1:0] n;
    logic             match;
    logic             overflow;
    logic [IW-1:0]    offset;
    logic [IW-1:0]    next_index;
    logic [CW-1:0]    next_first;
    logic [CW-1:0]    next_code;

    assign n = CNT_W'(len_at(VEC_W'(len_count), 32'(len_q), CNT_W));

    canon_huff_step #(
        .MAX_LEN (MAX_LEN),
        .NUM_SYM (NUM_SYM),
        .CNT_W   (CNT_W)
    ) u_step (
        .code_i       (code_q),
        .first_i      (first_q),
        .index_i      (index_q),
        .count_i      (n),
        .bit_i        (bit_in),
        .match_o      (match),
        .offset_o     (offset),
        .next_code_o  (next_code),
        .next_first_o (next_first),
        .next_index_o (next_index),
        .overflow_o   (overflow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            first_q <= '0;
            index_q <= '0;
            len_q   <= '0;
            total_q <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            first_q <= first_d;
            index_q <= index_d;
            len_q   <= len_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        first_d = first_q;
        index_d = index_q;
        len_d   = len_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    total_d = sym_total;
                    cnt_d   = '0;
                    code_d  = '0;
                    first_d = '0;
                    index_d = '0;
                    len_d   = LW'(1);
                    state_d = (sym_total == '0) ? ST_DONE : ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (bit_vld) begin
                    if (match) begin
                        if (overflow) begin
                            state_d = ST_ERR;
                        end else begin
                            wdata_d = SYM_W'(sym_at(VEC_W'(sym_table),
                                                    32'(offset), SYM_W));
                            state_d = ST_EMIT;
                        end
                    end else if (len_q == LW'(MAX_LEN)) begin
                        state_d = ST_ERR;
                    end else begin
                        code_d  = next_code;
                        first_d = next_first;
                        index_d = next_index;
                        len_d   = len_q + 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (!wfull) begin
                    cnt_d   = cnt_q + 1'b1;
                    code_d  = '0;
                    first_d = '0;
                    index_d = '0;
                    len_d   = LW'(1);
                    state_d = (cnt_d == total_q) ? ST_DONE : ST_DECODE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_req = (state_q == ST_DECODE);
        winc    = (state_q == ST_EMIT) && !wfull;
        busy    = (state_q == ST_DECODE) || (state_q == ST_EMIT);
        fin     = (state_q == ST_DONE);
        err     = (state_q == ST_ERR);
        wdata   = wdata_q;
    end

endmodule

// File: tb/tb_canon_huff_dec.sv
// Vector table, hand corner cases and random streams for canon_huff_dec.
module tb_canon_huff_dec;

    localparam int SYM_W   = 4;
    localparam int NUM_SYM = 16;
    localparam int MAX_LEN = 4;
    localparam int TOT_W   = 16;
    localparam int CNT_W   = 5;

    localparam logic [19:0] LC_MAIN = {5'd2, 5'd5, 5'd1, 5'd0};
    localparam logic [19:0] LC_ERR  = {5'd0, 5'd0, 5'd1, 5'd0};
    localparam logic [63:0] ST_MAIN = 64'h0000_0000_F942_10F5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [TOT_W-1:0] sym_total = '0;
    logic [MAX_LEN*CNT_W-1:0] len_count = LC_MAIN;
    logic [NUM_SYM*SYM_W-1:0] sym_table = ST_MAIN;
    logic bit_in = 1'b0;
    logic bit_vld = 1'b0;
    logic wfull = 1'b0;
    logic bit_req, winc, busy, fin, err;
    logic [SYM_W-1:0] wdata;

    always #5 clk = ~clk;

    canon_huff_dec #(
        .SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .MAX_LEN(MAX_LEN), .TOT_W(TOT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sym_total(sym_total),
        .len_count(len_count), .sym_table(sym_table),
        .bit_in(bit_in), .bit_vld(bit_vld), .bit_req(bit_req),
        .wdata(wdata), .winc(winc), .wfull(wfull),
        .busy(busy), .fin(fin), .err(err)
    );

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        logic [15:0] total;
        logic [19:0] lc;
        int          vmode;
        int          start_at;
        logic [31:0] exp;
        int          nexp;
        bit          exp_err;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic       bitq[$];
    logic [3:0] gotq[$];
    logic [3:0] expq[$];
    int consumed, done_c, last_w, overlap, stall_bad, full_n;
    bit fin_seen, err_seen, timeout;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // vmode: 0 always valid, 1 every other cycle, 2 random
    // fmode: 0 never full, 1 five full cycles in first EMIT, 2 random
    task automatic run(input logic [15:0] tot, input int vmode,
                       input int fmode, input int start_at, input int budget);
        bit nz;
        gotq.delete();
        consumed = 0; done_c = -1; last_w = -1; overlap = 0;
        stall_bad = 0; full_n = 0; fin_seen = 0; err_seen = 0; timeout = 1;
        @(negedge clk);
        start = 1'b1; sym_total = tot; bit_vld = 1'b0; wfull = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            start = (c == start_at);
            if (c == start_at) sym_total = 16'd3;
            nz = (bitq.size() > 0);
            bit_in = nz ? bitq[0] : 1'b0;
            if (vmode == 1)      bit_vld = (c % 2 == 0) && nz;
            else if (vmode == 2) bit_vld = ($urandom_range(0, 1) == 1) && nz;
            else                 bit_vld = nz;
            wfull = 1'b0;
            if (fmode == 2) wfull = ($urandom_range(0, 2) == 0);
            if (fmode == 1 && consumed == 3 && gotq.size() == 0 && full_n < 5) begin
                wfull = 1'b1;
                full_n++;
            end
            #1;
            if (fmode == 1 && wfull && (winc || wdata !== 4'd4 || bit_req))
                stall_bad++;
            if (bit_req && bit_vld) begin
                void'(bitq.pop_front());
                consumed++;
            end
            if (winc) begin
                gotq.push_back(wdata);
                last_w = c;
            end
            if (winc && bit_req) overlap++;
            if (fin || err) begin
                fin_seen = fin; err_seen = err; done_c = c; timeout = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; bit_vld = 1'b0; wfull = 1'b0;
    endtask

    task automatic check_run(input string id, input bit exp_err, input int nb);
        chk({id, "_timeout"}, timeout, 0);
        chk({id, "_err"}, err_seen, exp_err);
        chk({id, "_fin"}, fin_seen, !exp_err);
        chk({id, "_bits"}, consumed, nb);
        chk({id, "_req_in_emit"}, overlap, 0);
        chk({id, "_nsym"}, gotq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < gotq.size(); i++)
            chk($sformatf("%s_sym%0d", id, i), gotq[i], expq[i]);
        if (!exp_err && expq.size() > 0)
            chk({id, "_fin_gap"}, done_c - last_w, 1);
    endtask

    vec_t vt[5];
    int   avail, sum, code, idx, nsym, nb, k, n;
    int   lens[16];
    int   codes[16];
    logic [3:0] sy[16];

    initial begin
        vt[0] = '{{11'd0, 2'b00, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 4'b1110},
                  21, 16'd7, LC_MAIN, 0, -1, 32'h094210F5, 7, 1'b0};
        vt[1] = '{32'b1111, 4, 16'd1, LC_MAIN, 0, -1, 32'hF, 1, 1'b0};
        vt[2] = '{32'b1110, 4, 16'd1, LC_MAIN, 1, -1, 32'h9, 1, 1'b0};
        vt[3] = '{vt[0].bits, 21, 16'd7, LC_MAIN, 0, 5, 32'h094210F5, 7, 1'b0};
        vt[4] = '{32'b0111, 4, 16'd1, LC_ERR, 0, -1, 32'h0, 0, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {bit_req, winc, busy, fin, err, wdata}, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            len_count = vt[v].lc;
            sym_table = ST_MAIN;
            bitq.delete();
            expq.delete();
            for (int b = vt[v].nbits - 1; b >= 0; b--) bitq.push_back(vt[v].bits[b]);
            for (int i = 0; i < vt[v].nexp; i++) expq.push_back(vt[v].exp[i*4 +: 4]);
            run(vt[v].total, vt[v].vmode, 0, vt[v].start_at, 500);
            check_run($sformatf("vec%0d", v), vt[v].exp_err, vt[v].nbits);
        end

        // zero total straight after the error run: err clears, fin next cycle
        len_count = LC_MAIN;
        bitq.delete();
        expq.delete();
        run(16'd0, 0, 0, -1, 50);
        chk("zero_fin_cycle", done_c, 0);
        check_run("zero", 1'b0, 0);

        // backpressure on symbol 4 (code 110)
        bitq = '{1'b1, 1'b1, 1'b0};
        expq = '{4'd4};
        run(16'd1, 0, 1, -1, 200);
        chk("bp_full_cycles", full_n, 5);
        chk("bp_stall_bad", stall_bad, 0);
        check_run("bp", 1'b0, 3);

        // reset in the middle of decoding
        @(negedge clk);
        start = 1'b1; sym_total = 16'd7;
        @(negedge clk);
        start = 1'b0; bit_vld = 1'b1; bit_in = 1'b0;
        @(negedge clk);
        bit_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; bit_vld = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_mid", {bit_req, winc, busy, fin, err, wdata}, 0);
        rst_n = 1'b1;
        bitq.delete();
        expq.delete();
        for (int b = 20; b >= 0; b--) bitq.push_back(vt[0].bits[b]);
        for (int i = 0; i < 7; i++) expq.push_back(vt[0].exp[i*4 +: 4]);
        run(16'd7, 0, 0, -1, 500);
        check_run("after_rst", 1'b0, 21);

        // random canonical tables and symbol streams
        for (int r = 0; r < 20; r++) begin
            avail = 2; sum = 0; code = 0; idx = 0;
            len_count = '0;
            for (int L = 1; L <= 4; L++) begin
                n = $urandom_range(0, avail);
                if (L == 4 && sum == 0 && n == 0) n = 1;
                len_count[(L-1)*5 +: 5] = 5'(n);
                for (int j = 0; j < n; j++) begin
                    lens[idx] = L;
                    codes[idx] = code;
                    idx++;
                    code++;
                end
                sum += n;
                avail = (avail - n) * 2;
                code = code << 1;
            end
            for (int i = 0; i < 16; i++) begin
                sy[i] = 4'($urandom_range(0, 15));
                sym_table[i*4 +: 4] = sy[i];
            end
            bitq.delete();
            expq.delete();
            nsym = $urandom_range(1, 8);
            nb = 0;
            for (int s = 0; s < nsym; s++) begin
                k = $urandom_range(0, sum - 1);
                for (int b = lens[k] - 1; b >= 0; b--)
                    bitq.push_back(1'((codes[k] >> b) & 1));
                nb += lens[k];
                expq.push_back(sy[k]);
            end
            run(16'(nsym), 2, 2, -1, 2000);
            check_run($sformatf("rand%0d", r), 1'b0, nb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
